// File: rtl/ula_sequencial.sv
// Sequential 8-bit ALU: add, subtract, multiply by repeated addition and
// divide by repeated subtraction. A three-state FSM (IDLE/CALC/FIM) latches
// the operands when start is accepted, iterates in CALC and pulses done in FIM.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// CALC  | operation in progress (one or more cycles)
// FIM   | result valid, done pulses for exactly one cycle
module ula_sequencial (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] resultado,
  output logic [7:0]  resto,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIM  = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  state_t      state;
  state_t      state_next;

  // operands captured on the accepting edge so later input changes are inert
  logic [1:0]  op_r;
  logic [7:0]  a_r;
  logic [7:0]  b_r;

  // iteration registers
  logic [15:0] acc;
  logic [7:0]  cnt;
  logic [7:0]  rem;
  logic [7:0]  quo;

  logic        accept;
  logic        calc_done;
  logic [15:0] acc_sum;
  logic        rem_ge_b;

  assign accept   = (state == IDLE) && start;
  assign acc_sum  = acc + {8'h00, a_r};
  assign rem_ge_b = (rem >= b_r);

  // CALC exit condition: evaluated on the values held during this CALC cycle
  always_comb begin
    calc_done = 1'b0;
    case (op_r)
      OP_ADD: calc_done = 1'b1;
      OP_SUB: calc_done = 1'b1;
      // counter at 1 reaches 0 after this update; 0 means b was 0 (single cycle)
      OP_MUL: calc_done = (cnt <= 8'd1);
      OP_DIV: calc_done = (b_r == 8'h00) || !rem_ge_b;
      default: calc_done = 1'b1;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = CALC;
      CALC: if (calc_done) state_next = FIM;
      FIM:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs decoded from state only
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        done = 1'b0;
      end
      CALC: begin
        busy = 1'b1;
        done = 1'b0;
      end
      FIM: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // operand capture on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r <= OP_ADD;
      a_r  <= 8'h00;
      b_r  <= 8'h00;
    end else if (accept) begin
      op_r <= op;
      a_r  <= a;
      b_r  <= b;
    end
  end

  // multiply/divide iteration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= 16'h0000;
      cnt <= 8'h00;
      rem <= 8'h00;
      quo <= 8'h00;
    end else if (accept) begin
      acc <= 16'h0000;
      cnt <= b;
      rem <= a;
      quo <= 8'h00;
    end else if (state == CALC) begin
      case (op_r)
        OP_MUL: begin
          if (cnt != 8'h00) begin
            acc <= acc_sum;
            cnt <= cnt - 8'd1;
          end
        end
        OP_DIV: begin
          if ((b_r != 8'h00) && rem_ge_b) begin
            rem <= rem - b_r;
            quo <= quo + 8'd1;
          end
        end
        default: begin
          acc <= acc;
        end
      endcase
    end
  end

  // result registers: cleared on accept, written on the final CALC cycle, then held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resultado <= 16'h0000;
      resto     <= 8'h00;
      div_zero  <= 1'b0;
    end else if (accept) begin
      resultado <= 16'h0000;
      resto     <= 8'h00;
      div_zero  <= 1'b0;
    end else if (state == CALC) begin
      case (op_r)
        OP_ADD: resultado <= {8'h00, a_r} + {8'h00, b_r};
        OP_SUB: resultado <= {8'h00, a_r} - {8'h00, b_r};
        OP_MUL: begin
          // b=0 leaves resultado at the cleared value of 0
          if (cnt == 8'd1) begin
            resultado <= acc_sum;
          end
        end
        OP_DIV: begin
          if (b_r == 8'h00) begin
            resto    <= a_r;
            div_zero <= 1'b1;
          end else if (!rem_ge_b) begin
            resultado <= {8'h00, quo};
            resto     <= rem;
          end
        end
        default: resultado <= resultado;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_sequencial.sv
// Self-checking bench for ula_sequencial: a reference model pushes expected
// results into a scoreboard when an operation is started; a monitor pops and
// compares them (values and CALC cycle count) when done pulses.
module tb_ula_sequencial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] resultado;
  logic [7:0]  resto;
  logic        div_zero;

  typedef struct {
    logic [15:0] res;
    logic [7:0]  rem;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   calc_cnt = 0;

  ula_sequencial dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .resultado (resultado),
    .resto     (resto),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    e.res = 16'h0000;
    e.rem = 8'h00;
    e.dz  = 1'b0;
    e.cyc = 1;
    case (o)
      2'b00: e.res = {8'h00, x} + {8'h00, y};
      2'b01: e.res = {8'h00, x} - {8'h00, y};
      2'b10: begin
        e.res = {8'h00, x} * {8'h00, y};
        e.cyc = (y == 8'h00) ? 1 : int'(y);
      end
      default: begin
        if (y == 8'h00) begin
          e.rem = x;
          e.dz  = 1'b1;
        end else begin
          e.res = {8'h00, 8'(x / y)};
          e.rem = 8'(x % y);
          e.cyc = int'(x / y) + 1;
        end
      end
    endcase
    return e;
  endfunction

  // monitor: count CALC cycles, compare against scoreboard on done
  always @(negedge clk) begin
    if (rst) begin
      calc_cnt = 0;
    end else if (done) begin
      chk("done_has_txn", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("resultado", 32'(resultado), 32'(mon_e.res));
        chk("resto", 32'(resto), 32'(mon_e.rem));
        chk("div_zero", 32'(div_zero), 32'(mon_e.dz));
        chk("calc_cycles", 32'(calc_cnt), 32'(mon_e.cyc));
      end
      calc_cnt = 0;
    end else if (busy) begin
      calc_cnt++;
    end
  end

  // start one operation at a negedge; optionally pulse start again while busy
  task automatic run_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y, input int poke);
    exp_t e;
    bit   seen;
    int   guard;
    guard = 0;
    while (busy && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    e = model(o, x, y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    a     = 8'($urandom);
    b     = 8'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    seen = 1'b0;
    for (int k = 1; k <= 400 && !seen; k++) begin
      @(negedge clk);
      if (k == poke) begin
        start = 1'b1;
        op    = 2'b00;
        a     = 8'd1;
        b     = 8'd1;
      end else if (k == poke + 1) begin
        start = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    if (!seen) sb.delete();
    @(negedge clk);
    chk("idle_after_fim", 32'(busy), 32'd0);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("hold_resultado", 32'(resultado), 32'(e.res));
    chk("hold_resto", 32'(resto), 32'(e.rem));
    chk("hold_div_zero", 32'(div_zero), 32'(e.dz));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = 8'h00;
    b     = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_resultado", 32'(resultado), 32'd0);
    chk("rst_resto", 32'(resto), 32'd0);
    chk("rst_div_zero", 32'(div_zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(2'b00, 8'd200, 8'd100, 0);
    run_op(2'b01, 8'd3,   8'd5,   0);
    run_op(2'b10, 8'd255, 8'd255, 0);
    run_op(2'b11, 8'd17,  8'd5,   0);
    run_op(2'b11, 8'd9,   8'd0,   0);
    run_op(2'b10, 8'd7,   8'd0,   0);
    run_op(2'b11, 8'd0,   8'd7,   0);
    run_op(2'b11, 8'd4,   8'd9,   0);
    run_op(2'b10, 8'd2,   8'd10,  3);

    // abort a long divide in its third CALC cycle
    op    = 2'b11;
    a     = 8'd200;
    b     = 8'd1;
    start = 1'b1;
    sb.push_back(model(2'b11, 8'd200, 8'd1));
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("busy_before_abort", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    sb.delete();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_resultado", 32'(resultado), 32'd0);
    chk("abort_resto", 32'(resto), 32'd0);
    chk("abort_div_zero", 32'(div_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_done_after_abort", 32'(done), 32'd0);
    end
    run_op(2'b00, 8'd1, 8'd1, 0);

    for (int i = 0; i < 16; i++) begin
      run_op(2'($urandom), 8'($urandom), 8'($urandom_range(0, 40)), 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
